reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//   Generates staged active-low resets (rst_n_out) for downstream flops that use async-clear style
//   (posedge clk or negedge rst_n). All stages assert together; they release in order, bit 0 first.
//   Reset sources: master reset, glitch-filtered external request, software pulse request.
//   Sits directly upstream of every asynchronously-reset register bank in the clock domain.
// PARAMETERS
//   N_STAGES      3   number of reset outputs; bit 0 releases first (>=1)
//   ASSERT_CYCLES 16  minimum cycles all outputs are held low after the last trigger (>=2)
//   STAGE_GAP     4   cycles between successive stage releases (>=1)
//   FILTER_LEN    3   consecutive high samples of ext_rst_req needed to accept it (>=1)
// PORTS
//   clk          in   1         single clock; all logic is posedge clk
//   rst          in   1         synchronous, active-high master reset
//   ext_rst_req  in   1         external reset request level, already synchronised to clk
//   sw_rst_req   in   1         software reset request, 1-cycle pulse
//   rst_n_out    out  N_STAGES  active-low stage resets, all registered
//   rst_busy     out  1         high while any rst_n_out bit is 0, registered
//   sw_rst_ack   out  1         1-cycle pulse: software-triggered sequence complete
// BEHAVIOUR
//   - Reset: rst sampled high -> state ASSERT, cnt=0, rst_n_out=0, rst_busy=1, sw_rst_ack=0,
//     filter count=0, sw_pend=0. rst takes priority over every other input.
//   - Trigger edge: any edge that samples rst, an accepted ext request, or sw_rst_req.
//     Effect is identical in every state: next state ASSERT, cnt=0, rst_n_out=0, rst_busy=1.
//   - Timing, with trigger at edge Ek: rst_n_out[i] rises at Ek+ASSERT_CYCLES+i*STAGE_GAP.
//     With the defaults: bit0 at Ek+16, bit1 at Ek+20, bit2 at Ek+24.
//   - FSM ASSERT: cnt increments each edge; at cnt==ASSERT_CYCLES-1 -> RELEASE, bit0 set, cnt=0.
//   - FSM RELEASE: every STAGE_GAP edges the next bit is set.
//     The edge setting bit N_STAGES-1 -> RUN; rst_busy falls on that same edge.
//   - FSM RUN: all outputs 1. Stays in RUN until a trigger.
//   - Release order is monotonic: a bit never rises before the bit below it.
//     Outputs are never partially re-asserted; any trigger clears all bits together.
//   - Ext filter: counter increments while ext_rst_req=1 and clears to 0 when ext_rst_req=0.
//     It saturates at FILTER_LEN. Every edge with ext_rst_req=1 and count reaching FILTER_LEN
//     is an accepted trigger. A level held high keeps retriggering, so outputs stay low
//     until ASSERT_CYCLES after the last high sample. Pulses shorter than FILTER_LEN are ignored.
//   - sw_rst_req sampled high (not rst) -> trigger and sw_pend=1. sw_pend is cleared by rst.
//     An ext trigger does not clear sw_pend.
//   - sw_rst_ack = 1 for exactly one cycle, on the edge entering RUN, if sw_pend=1.
//     That edge also clears sw_pend.
//   - Simultaneous sw and ext trigger: single trigger; sw_pend=1.
//   - Trigger during RELEASE: released bits drop to 0 on the next edge; the full sequence restarts.
//   - rst mid-sequence: full restart; a pending sw ack is discarded, with no ack at completion.
// TESTING
//   1 rst=1 x5, then 0 (first rst=0 edge E1): rst_n_out=000 until E16; 001@E16, 011@E20, 111@E24;
//     rst_busy falls @E24; sw_rst_ack stays 0.
//   2 RUN, sw_rst_req pulse sampled @Ek: rst_n_out=000 after Ek; 001@Ek+16; 111@Ek+24;
//     sw_rst_ack=1 only in the cycle after Ek+24.
//   3 RUN, ext_rst_req high for 2 cycles -> no change. High for 3 samples (3rd @Ek) ->
//     000 after Ek; 111@Ek+24; no ack.
//   4 ext_rst_req held high 40 cycles, last high sample @Em: outputs stay 000;
//     001@Em+16; 111@Em+24.
//   5 After test 1, sw_rst_req @E18 (bit0 already 1): 000 after E18; 001@E34; 111@E42;
//     ack pulse after E42.
//   6 sw_rst_req @Ek, then rst=1 @Ek+10 for 1 cycle: 000 throughout; 111 at 24 edges after rst;
//     sw_rst_ack never pulses.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged active-low reset generator: all stages assert together and release
// in order (bit 0 first) after a trigger from master, external or software request.
module reset_sequencer #(
    parameter int unsigned N_STAGES      = 3,
    parameter int unsigned ASSERT_CYCLES = 16,
    parameter int unsigned STAGE_GAP     = 4,
    parameter int unsigned FILTER_LEN    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ext_rst_req,
    input  logic                sw_rst_req,
    output logic [N_STAGES-1:0] rst_n_out,
    output logic                rst_busy,
    output logic                sw_rst_ack
);

    localparam int unsigned CNT_MAX = (ASSERT_CYCLES > STAGE_GAP) ? ASSERT_CYCLES : STAGE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FILT_W  = $clog2(FILTER_LEN + 1);
    localparam logic [N_STAGES-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [FILT_W-1:0]     filt_q;
    logic [FILT_W-1:0]     filt_d;
    logic [N_STAGES-1:0]   out_q;
    logic                  busy_q;
    logic                  ack_q;
    logic                  pend_q;
    logic                  ext_trig_c;
    logic                  trig_c;
    logic                  step_c;
    logic [N_STAGES-1:0]   next_bits_c;

    // Saturating run-length of high ext_rst_req samples.
    always_comb begin
        filt_d = '0;
        if (ext_rst_req) begin
            filt_d = (filt_q == FILT_W'(FILTER_LEN)) ? filt_q : filt_q + FILT_W'(1);
        end
    end

    assign ext_trig_c = ext_rst_req && (filt_d == FILT_W'(FILTER_LEN));
    assign trig_c     = ext_trig_c || sw_rst_req;

    // In ASSERT out_q is all zero, so the same shift yields bit 0 for the first release.
    assign step_c = ((state_q == ST_ASSERT)  && (cnt_q == CNT_W'(ASSERT_CYCLES - 1))) ||
                    ((state_q == ST_RELEASE) && (cnt_q == CNT_W'(STAGE_GAP - 1)));
    assign next_bits_c = N_STAGES'({out_q, 1'b1});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            filt_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            filt_q <= filt_d;
            ack_q  <= 1'b0;
            if (sw_rst_req) begin
                pend_q <= 1'b1;
            end
            if (trig_c) begin
                state_q <= ST_ASSERT;
                cnt_q   <= '0;
                out_q   <= '0;
                busy_q  <= 1'b1;
            end else if (step_c) begin
                cnt_q <= '0;
                out_q <= next_bits_c;
                if (next_bits_c == ALL_ONES) begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                    ack_q   <= pend_q;
                    pend_q  <= 1'b0;
                end else begin
                    state_q <= ST_RELEASE;
                end
            end else if (state_q != ST_RUN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign rst_n_out  = out_q;
    assign rst_busy   = busy_q;
    assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timing model built from the release
// schedule (edges since last trigger) predicts outputs; a monitor compares.
module tb_reset_sequencer;

    localparam int unsigned N = 3;
    localparam int unsigned A = 16;
    localparam int unsigned G = 4;
    localparam int unsigned F = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ext_rst_req = 1'b0;
    logic         sw_rst_req = 1'b0;
    logic [N-1:0] rst_n_out;
    logic         rst_busy;
    logic         sw_rst_ack;

    reset_sequencer #(
        .N_STAGES(N), .ASSERT_CYCLES(A), .STAGE_GAP(G), .FILTER_LEN(F)
    ) dut (
        .clk(clk), .rst(rst), .ext_rst_req(ext_rst_req), .sw_rst_req(sw_rst_req),
        .rst_n_out(rst_n_out), .rst_busy(rst_busy), .sw_rst_ack(sw_rst_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] outs;
        logic         busy;
        logic         ack;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   acks_seen = 0;

    // Reference model: outputs are a pure function of edges elapsed since the last trigger.
    int  edge_no = 0;
    int  last_trig = 0;
    int  ext_run = 0;
    bit  pend = 1'b0;
    bit  model_valid = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        int   el;
        bit   trig;
        bit   ack;
        edge_no++;
        ack = 1'b0;
        if (rst) begin
            model_valid = 1'b1;
            last_trig   = edge_no;
            pend        = 1'b0;
            ext_run     = 0;
        end else if (model_valid) begin
            ext_run = ext_rst_req ? ext_run + 1 : 0;
            trig = (ext_rst_req && ext_run >= F) || sw_rst_req;
            if (sw_rst_req) pend = 1'b1;
            if (trig) begin
                last_trig = edge_no;
            end else if ((edge_no - last_trig) == A + (N - 1) * G && pend) begin
                ack  = 1'b1;
                pend = 1'b0;
            end
        end
        if (model_valid) begin
            el = edge_no - last_trig;
            for (int i = 0; i < N; i++) e.outs[i] = (el >= A + i * G);
            e.busy = ~&e.outs;
            e.ack  = ack;
            exp_q.push_back(e);
        end
    end

    // Monitor: sample just after the edge and compare against the oldest prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (sw_rst_ack) acks_seen++;
            if ({rst_n_out, rst_busy, sw_rst_ack} !== e) begin
                bad++;
                $display("FAIL cycle t=%0t edge=%0d got out=%b busy=%b ack=%b want out=%b busy=%b ack=%b",
                         $time, edge_no, rst_n_out, rst_busy, sw_rst_ack, e.outs, e.busy, e.ack);
            end
        end
    end

    task automatic cyc(input logic r, input logic x, input logic s);
        rst = r;
        ext_rst_req = x;
        sw_rst_req = s;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int ext_left;
        int acks_before;
        // Power-on reset and full release.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
        idle(30);
        // Software request while bit 0 is already released (sampled at E18).
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
        idle(17);
        cyc(1'b0, 1'b0, 1'b1);
        idle(40);
        // Software request from RUN.
        cyc(1'b0, 1'b0, 1'b1);
        idle(30);
        // Short ext pulse ignored, then a just-long-enough one.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        idle(30);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        idle(30);
        // Ext held high for 40 cycles keeps retriggering.
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b0);
        idle(30);
        // Software request then master reset mid-sequence: no ack expected.
        acks_before = acks_seen;
        cyc(1'b0, 1'b0, 1'b1);
        idle(9);
        cyc(1'b1, 1'b0, 1'b0);
        idle(40);
        total++;
        if (acks_seen != acks_before) begin
            bad++;
            $display("FAIL rst_discards_ack got acks=%0d want 0", acks_seen - acks_before);
        end
        // Simultaneous sw and ext trigger.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        idle(30);
        // Randomized traffic.
        ext_left = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r, x, s;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 59) == 0);
            if (ext_left == 0 && $urandom_range(0, 39) == 0)
                ext_left = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 5);
            x = (ext_left > 0);
            if (ext_left > 0) ext_left--;
            cyc(r, x, s);
        end
        idle(40);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
